alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Registered single-cycle integer execution unit (functional unit) for the out-of-order RV32I core.
- Sits behind the dispatch/issue stage and receives one fired reservation-station entry per cycle: opcode, func3, func7, two 32-bit operands and a 6-bit physical destination tag.
- One cycle later it returns the 32-bit result with the tag and a valid flag for the writeback/ROB broadcast.
- Operands arrive fully resolved: src2 already holds the immediate for I-type operations.

Parameters:
- XLEN, 32, operand/result width.
- TAGW, 6, physical register tag width (64 physical registers).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  issue strobe; operands are sampled when high.
- opcode_i  in  7  RISC-V opcode field.
- func3_i  in  3  funct3 field.
- func7_i  in  7  funct7 field; bit 5 selects SUB, SRA or SRAI.
- src1_i  in  XLEN  operand 1 (rs1 value).
- src2_i  in  XLEN  operand 2 (rs2 value or pre-formed immediate).
- dest_i  in  TAGW  destination physical register tag.
- result_o  out  XLEN  registered result.
- dest_o  out  TAGW  registered destination tag.
- valid_o  out  1  result valid, one-cycle pulse per issued op.
- illegal_o  out  1  high with valid_o when the opcode/func combination is unsupported.

Behaviour:
- Reset (sync, high): result_o=0, dest_o=0, valid_o=0, illegal_o=0 on the next edge. Reset has priority over a simultaneous valid_i; an in-flight op is dropped.
- Latency is exactly 1 cycle. An op sampled on edge N appears on the outputs after edge N.
- Throughput is one op per cycle with back-to-back issue; there is no stall and no ready signal.
- valid_i low at an edge: valid_o=0, illegal_o=0; result_o and dest_o hold their previous values.
- dest_o = dest_i registered, unmodified, for every accepted op, including illegal ones.
- Opcode 0110011 (R-type), by func3 / func7[5]:
  - 000/0 ADD; 000/1 SUB.
  - 001 SLL by src2[4:0].
  - 010 SLT, signed; 011 SLTU, unsigned. Both produce 0 or 1.
  - 100 XOR.
  - 101/0 SRL; 101/1 SRA (arithmetic, sign fill).
  - 110 OR; 111 AND.
- Opcode 0010011 (I-type), src2 used as given with no re-extension:
  - 000 ADDI; 010 SLTI; 011 SLTIU; 100 XORI; 110 ORI; 111 ANDI.
  - 001 SLLI, shamt = src2[4:0].
  - 101 SRLI when func7[5]=0, SRAI when func7[5]=1.
- Opcode 0000011 (LW) and 0100011 (SW): result = src1 + src2 (effective address).
- Any other opcode: result_o=0 and illegal_o=1 with valid_o=1.
- func7 bits other than bit 5 are ignored. R-type func3 values other than 000/101 ignore func7[5].
- Arithmetic is modulo 2^32: overflow wraps, carry is discarded, no flags.
- Shift amount uses only the low 5 bits; a shift amount of 0 passes the value through unchanged.

Test Plan:
- Reset then idle: assert reset for 2 cycles with valid_i=1 -> valid_o=0, result_o=0, dest_o=0 throughout.
- ADD and SUB wrap:
  - ADD (0110011/000/0000000), src1=0xFFFFFFFF, src2=0x00000002, dest=0x2A -> next cycle result_o=0x00000001, dest_o=0x2A, valid_o=1.
  - SUB, src1=0, src2=1 -> 0xFFFFFFFF.
- ADDI and ANDI:
  - 0010011/000, src1=0x00000010, src2=0x00000005 -> 0x00000015.
  - 0010011/111, src1=0x0000F0F0, src2=0x000000FF -> 0x000000F0.
- Shifts and compares:
  - SRA, src1=0x80000000, src2=0x24 (shamt 4) -> 0xF8000000.
  - SRL same operands -> 0x08000000.
  - SLT with src1=0xFFFFFFFF, src2=1 -> 1; SLTU same operands -> 0.
- Back-to-back and hold:
  - Issue XOR 0xAAAA5555^0xFFFF0000 then LW address 0x1000+0x4 on consecutive cycles -> 0x5555_5555 then 0x00001004, valid_o high both cycles.
  - Then valid_i=0 -> valid_o=0 and result_o holds 0x00001004.
- Illegal op and reset priority:
  - opcode 1100011 -> valid_o=1, illegal_o=1, result_o=0.
  - Issue ADD with reset asserted on the same edge -> valid_o=0.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the reservation-station fire port and the ALU.
// The master drives the issue side and the slave returns the registered result.
interface alu_exec_unit_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 6
);
  logic            valid_i;
  logic [6:0]      opcode_i;
  logic [2:0]      func3_i;
  logic [6:0]      func7_i;
  logic [XLEN-1:0] src1_i;
  logic [XLEN-1:0] src2_i;
  logic [TAGW-1:0] dest_i;
  logic [XLEN-1:0] result_o;
  logic [TAGW-1:0] dest_o;
  logic            valid_o;
  logic            illegal_o;

  modport master (
    output valid_i, opcode_i, func3_i, func7_i, src1_i, src2_i, dest_i,
    input  result_o, dest_o, valid_o, illegal_o
  );

  modport slave (
    input  valid_i, opcode_i, func3_i, func7_i, src1_i, src2_i, dest_i,
    output result_o, dest_o, valid_o, illegal_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered single-cycle RV32I integer ALU: one op per cycle in, result and
// destination tag out one cycle later for writeback/ROB broadcast.
module alu_exec_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 6
) (
  input logic             clk,
  input logic             reset,
  alu_exec_unit_if.slave  bus
);

  typedef enum logic [6:0] {
    OP_REG   = 7'b0110011,
    OP_IMM   = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011
  } opcode_e;

  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [4:0]      shamt;
  logic            alt;
  logic            is_reg;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] res;
  logic            illegal;

  assign src1   = bus.src1_i;
  assign src2   = bus.src2_i;
  assign shamt  = bus.src2_i[4:0];
  assign alt    = bus.func7_i[5];
  assign is_reg = (bus.opcode_i == OP_REG);

  // Shared datapath for register and immediate forms; only R-type 000 honours
  // func7[5] as SUB, while 101 honours it for both SRA and SRAI.
  always_comb begin
    alu_res = '0;
    unique case (bus.func3_i)
      3'b000:  alu_res = (is_reg && alt) ? (src1 - src2) : (src1 + src2);
      3'b001:  alu_res = src1 << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
      3'b100:  alu_res = src1 ^ src2;
      3'b101:  alu_res = alt ? XLEN'($signed(src1) >>> shamt) : (src1 >> shamt);
      3'b110:  alu_res = src1 | src2;
      3'b111:  alu_res = src1 & src2;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (bus.opcode_i)
      OP_REG, OP_IMM:   res = alu_res;
      OP_LOAD, OP_STORE: res = src1 + src2;
      default:          illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result_o  <= '0;
      bus.dest_o    <= '0;
      bus.valid_o   <= 1'b0;
      bus.illegal_o <= 1'b0;
    end else begin
      bus.valid_o   <= bus.valid_i;
      bus.illegal_o <= bus.valid_i & illegal;
      if (bus.valid_i) begin
        bus.result_o <= res;
        bus.dest_o   <= bus.dest_i;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expected responses,
// a negedge monitor pops and compares whenever valid_o is presented.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] result;
    logic [5:0]  dest;
    logic        illegal;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  exp_t sb[$];

  alu_exec_unit_if #(.XLEN(32), .TAGW(6)) bus ();

  alu_exec_unit #(.XLEN(32), .TAGW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag,
                       input logic [31:0] exp_res, input logic exp_ill);
    exp_t e;
    bus.valid_i  = 1'b1;
    bus.opcode_i = op;
    bus.func3_i  = f3;
    bus.func7_i  = f7;
    bus.src1_i   = a;
    bus.src2_i   = b;
    bus.dest_i   = tag;
    e.result  = exp_res;
    e.dest    = tag;
    e.illegal = exp_ill;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid_o=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result_o, e.result);
        check("dest", {26'd0, bus.dest_o}, {26'd0, e.dest});
        check("illegal", {31'd0, bus.illegal_o}, {31'd0, e.illegal});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.valid_i  = 1'b1;
    bus.opcode_i = R;
    bus.func3_i  = 3'b000;
    bus.func7_i  = 7'h00;
    bus.src1_i   = 32'h1;
    bus.src2_i   = 32'h2;
    bus.dest_i   = 6'h3F;

    repeat (2) begin
      @(negedge clk);
      check("reset_valid", {31'd0, bus.valid_o}, 32'd0);
      check("reset_result", bus.result_o, 32'd0);
      check("reset_dest", {26'd0, bus.dest_o}, 32'd0);
    end
    reset = 1'b0;
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;

    issue(R, 3'b000, 7'h00, 32'hFFFFFFFF, 32'h00000002, 6'h2A, 32'h00000001, 1'b0);
    issue(R, 3'b000, 7'h20, 32'h00000000, 32'h00000001, 6'h01, 32'hFFFFFFFF, 1'b0);
    issue(I, 3'b000, 7'h00, 32'h00000010, 32'h00000005, 6'h02, 32'h00000015, 1'b0);
    issue(I, 3'b111, 7'h00, 32'h0000F0F0, 32'h000000FF, 6'h03, 32'h000000F0, 1'b0);
    issue(R, 3'b101, 7'h20, 32'h80000000, 32'h00000024, 6'h04, 32'hF8000000, 1'b0);
    issue(R, 3'b101, 7'h00, 32'h80000000, 32'h00000024, 6'h05, 32'h08000000, 1'b0);
    issue(R, 3'b010, 7'h00, 32'hFFFFFFFF, 32'h00000001, 6'h06, 32'h00000001, 1'b0);
    issue(R, 3'b011, 7'h00, 32'hFFFFFFFF, 32'h00000001, 6'h07, 32'h00000000, 1'b0);
    // shamt 0 passes through; SRAI via func7[5]; ADDI ignores func7[5]
    issue(R, 3'b001, 7'h00, 32'h12345678, 32'h00000020, 6'h08, 32'h12345678, 1'b0);
    issue(R, 3'b001, 7'h00, 32'h00000003, 32'h00000004, 6'h09, 32'h00000030, 1'b0);
    issue(I, 3'b101, 7'h20, 32'hF0000000, 32'h00000401, 6'h0A, 32'hF8000000, 1'b0);
    issue(I, 3'b000, 7'h20, 32'h00000003, 32'h00000004, 6'h0B, 32'h00000007, 1'b0);
    issue(I, 3'b011, 7'h00, 32'h00000005, 32'hFFFFFFFF, 6'h0C, 32'h00000001, 1'b0);
    issue(I, 3'b010, 7'h00, 32'h00000005, 32'hFFFFFFFF, 6'h0D, 32'h00000000, 1'b0);
    issue(R, 3'b110, 7'h20, 32'h0F000000, 32'h000000F0, 6'h0E, 32'h0F0000F0, 1'b0);
    issue(SW, 3'b010, 7'h00, 32'h7FFFFFFF, 32'h00000001, 6'h0F, 32'h80000000, 1'b0);
    issue(R, 3'b100, 7'h00, 32'hAAAA5555, 32'hFFFF0000, 6'h10, 32'h55555555, 1'b0);
    issue(LW, 3'b010, 7'h00, 32'h00001000, 32'h00000004, 6'h11, 32'h00001004, 1'b0);

    bus.valid_i = 1'b0;
    bus.src1_i  = 32'hDEADBEEF;
    bus.dest_i  = 6'h33;
    @(posedge clk);
    #1;
    check("idle_valid", {31'd0, bus.valid_o}, 32'd0);
    check("hold_result", bus.result_o, 32'h00001004);
    check("hold_dest", {26'd0, bus.dest_o}, 32'h11);

    issue(7'b1100011, 3'b000, 7'h00, 32'h00000001, 32'h00000002, 6'h12, 32'h00000000, 1'b1);

    // ADD issued on the reset edge must be dropped, so nothing is queued
    bus.valid_i  = 1'b1;
    bus.opcode_i = R;
    bus.func3_i  = 3'b000;
    bus.func7_i  = 7'h00;
    bus.src1_i   = 32'h5;
    bus.src2_i   = 32'h6;
    bus.dest_i   = 6'h15;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_prio_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_prio_result", bus.result_o, 32'd0);
    check("rst_prio_illegal", {31'd0, bus.illegal_o}, 32'd0);
    reset = 1'b0;
    bus.valid_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
